// File: rtl/tdc_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : tdc_pkg
//  Purpose  : Shared TDC definitions: readout FSM state encoding and the
//             default frame geometry used by the readout and capture blocks.
//  Revision : 1.0  initial release
// ============================================================================
package tdc_pkg;

   // Default frame geometry: samples per frame, sample width, buffer address width
   localparam int TDC_DEPTH = 500;
   localparam int TDC_DW    = 8;
   localparam int TDC_AW    = 9;

   // Readout FSM states
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_FETCH = 2'd1,
      ST_SEND  = 2'd2,
      ST_CSUM  = 2'd3
   } tdc_state_e;

endpackage : tdc_pkg
`default_nettype wire

// File: rtl/tdc_readout.sv
`default_nettype none
// ============================================================================
//  Module   : tdc_readout
//  Purpose  : On a start rising edge, streams DEPTH samples from the sample
//             buffer over a valid/ready link, followed by a mod-2**DW
//             checksum beat flagged with tx_last, then pulses done.
//  Revision : 1.0  initial release
// ============================================================================
module tdc_readout
   import tdc_pkg::*;
#(
   parameter int DEPTH = TDC_DEPTH,
   parameter int DW    = TDC_DW,
   parameter int AW    = TDC_AW
) (
   input  logic          clk,
   input  logic          rst,        // asynchronous, active low
   input  logic          start,
   output logic [AW-1:0] rd_addr,
   input  logic [DW-1:0] rd_data,
   output logic [DW-1:0] tx_data,
   output logic          tx_valid,
   input  logic          tx_ready,
   output logic          tx_last,
   output logic          busy,
   output logic          done
);

   localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

   tdc_state_e    state_q, state_d;
   logic          start_q;
   logic [AW-1:0] rd_addr_q, rd_addr_d;
   logic [DW-1:0] sum_q, sum_d;
   logic [DW-1:0] tx_data_q, tx_data_d;
   logic          tx_valid_q, tx_valid_d;
   logic          tx_last_q, tx_last_d;
   logic          done_q, done_d;

   logic          start_edge;
   logic          xfer;

   assign start_edge = start & ~start_q;
   assign xfer       = tx_valid_q & tx_ready;

   // State and datapath registers; reset clears everything so outputs drop at once
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= ST_IDLE;
         start_q    <= 1'b0;
         rd_addr_q  <= '0;
         sum_q      <= '0;
         tx_data_q  <= '0;
         tx_valid_q <= 1'b0;
         tx_last_q  <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         start_q    <= start;
         rd_addr_q  <= rd_addr_d;
         sum_q      <= sum_d;
         tx_data_q  <= tx_data_d;
         tx_valid_q <= tx_valid_d;
         tx_last_q  <= tx_last_d;
         done_q     <= done_d;
      end
   end

   // Next-state logic: fetch a sample, hold it until accepted, finish with the checksum
   always_comb begin
      state_d    = state_q;
      rd_addr_d  = rd_addr_q;
      sum_d      = sum_q;
      tx_data_d  = tx_data_q;
      tx_valid_d = tx_valid_q;
      tx_last_d  = tx_last_q;
      done_d     = 1'b0;
      case (state_q)
         ST_IDLE: begin
            // An edge coinciding with the done pulse is dropped, not deferred
            if (start_edge && !done_q) begin
               rd_addr_d = '0;
               sum_d     = '0;
               state_d   = ST_FETCH;
            end
         end
         ST_FETCH: begin
            tx_data_d  = rd_data;
            tx_valid_d = 1'b1;
            state_d    = ST_SEND;
         end
         ST_SEND: begin
            if (xfer) begin
               sum_d      = sum_q + tx_data_q;
               tx_valid_d = 1'b0;
               if (rd_addr_q == LAST_ADDR) begin
                  // Checksum includes the sample being accepted right now
                  tx_data_d  = sum_q + tx_data_q;
                  tx_valid_d = 1'b1;
                  tx_last_d  = 1'b1;
                  state_d    = ST_CSUM;
               end else begin
                  rd_addr_d = rd_addr_q + 1'b1;
                  state_d   = ST_FETCH;
               end
            end
         end
         ST_CSUM: begin
            if (xfer) begin
               tx_valid_d = 1'b0;
               tx_last_d  = 1'b0;
               done_d     = 1'b1;
               state_d    = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   assign rd_addr  = rd_addr_q;
   assign tx_data  = tx_data_q;
   assign tx_valid = tx_valid_q;
   assign tx_last  = tx_last_q;
   assign busy     = (state_q != ST_IDLE);
   assign done     = done_q;

endmodule : tdc_readout
`default_nettype wire

// File: tb/tb_tdc_readout.sv
`default_nettype none
// ============================================================================
//  Module   : tb_tdc_readout
//  Purpose  : Directed self-checking bench for tdc_readout. Main instance uses
//             DEPTH=500 with buffer model rd_data = rd_addr[7:0]; a second
//             instance uses DEPTH=1 with a constant 0xFF buffer.
//  Revision : 1.0  initial release
// ============================================================================
module tb_tdc_readout;

   localparam int DEPTH = 500;
   localparam int DW    = 8;
   localparam int AW    = 9;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          start = 1'b0;
   logic          tx_ready = 1'b0;
   logic [AW-1:0] rd_addr;
   logic [DW-1:0] rd_data;
   logic [DW-1:0] tx_data;
   logic          tx_valid, tx_last, busy, done;

   logic          start1 = 1'b0;
   logic          ready1 = 1'b1;
   logic [0:0]    rd_addr1;
   logic [DW-1:0] rd_data1;
   logic [DW-1:0] tx_data1;
   logic          tx_valid1, tx_last1, busy1, done1;

   always #5 clk = ~clk;

   assign rd_data  = rd_addr[7:0];
   assign rd_data1 = 8'hFF;

   tdc_readout #(.DEPTH(DEPTH), .DW(DW), .AW(AW)) dut (
      .clk(clk), .rst(rst), .start(start),
      .rd_addr(rd_addr), .rd_data(rd_data),
      .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
      .tx_last(tx_last), .busy(busy), .done(done)
   );

   tdc_readout #(.DEPTH(1), .DW(DW), .AW(1)) dut1 (
      .clk(clk), .rst(rst), .start(start1),
      .rd_addr(rd_addr1), .rd_data(rd_data1),
      .tx_data(tx_data1), .tx_valid(tx_valid1), .tx_ready(ready1),
      .tx_last(tx_last1), .busy(busy1), .done(done1)
   );

   int checks   = 0;
   int failures = 0;

   logic [7:0] beats[$];
   logic       lasts[$];
   int         done_cnt, busy_cycles, stall_bad, first_valid, busy_after_done;
   bit         timed_out;

   // Model: sample i carries i[7:0], only the final (checksum) beat has tx_last
   function automatic int seq_errors();
      int errs;
      logic [7:0] e;
      errs = 0;
      if (beats.size() != DEPTH + 1) return -1;
      for (int i = 0; i < DEPTH; i++) begin
         e = 8'(i);
         if (beats[i] !== e || lasts[i] !== 1'b0) errs++;
      end
      if (lasts[DEPTH] !== 1'b1) errs++;
      return errs;
   endfunction

   // Model checksum: sum of all sample values mod 256
   function automatic logic [7:0] model_csum();
      logic [7:0] s;
      s = 8'h00;
      for (int i = 0; i < DEPTH; i++) s = s + 8'(i);
      return s;
   endfunction

   function automatic logic [7:0] got_csum();
      if (beats.size() != DEPTH + 1) return 8'hxx;
      return beats[DEPTH];
   endfunction

   // Drive one frame on the main instance and log beats and statistics.
   // Inputs change and outputs are sampled on the falling edge.
   task automatic run_frame(input bit rnd_ready, input int restart_at, input int hold_cycles,
                            input bit start_on_done, input int stop_at);
      int         cyc, hold, tail;
      bit         restarted, prev_stall;
      logic [7:0] prev_data;
      beats.delete();
      lasts.delete();
      done_cnt = 0; busy_cycles = 0; stall_bad = 0; first_valid = -1;
      busy_after_done = 0; timed_out = 0;
      restarted = 0; prev_stall = 0; prev_data = 8'h00; tail = -1; cyc = 0;
      @(negedge clk);
      start = 1'b1;
      hold = hold_cycles;
      tx_ready = 1'b1;
      while (1) begin
         @(negedge clk);
         cyc++;
         if (busy) begin
            if (tail >= 0) busy_after_done++;
            else busy_cycles++;
         end
         if (hold > 0) begin
            hold--;
            if (hold == 0) start = 1'b0;
         end
         if (done) begin
            done_cnt++;
            if (tail < 0) begin
               tail = 6;
               if (start_on_done) begin
                  start = 1'b1;
                  hold = 1;
               end
            end
         end
         if (restart_at >= 0 && !restarted && beats.size() == restart_at) begin
            start = 1'b1;
            hold = 1;
            restarted = 1;
         end
         if (tx_valid && first_valid < 0) first_valid = cyc;
         if (prev_stall && (tx_valid !== 1'b1 || tx_data !== prev_data)) stall_bad++;
         tx_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
         if (tx_valid && tx_ready) begin
            beats.push_back(tx_data);
            lasts.push_back(tx_last);
         end
         prev_stall = tx_valid && !tx_ready;
         prev_data  = tx_data;
         if (stop_at >= 0 && beats.size() == stop_at) break;
         if (tail >= 0) begin
            if (tail == 0) break;
            tail--;
         end
         if (cyc >= 30000) begin
            timed_out = 1;
            break;
         end
      end
      start = 1'b0;
   endtask

   // Reset values, then start held high through reset release launches a frame
   task automatic test_reset();
      int n;
      bit seen;
      #1;
      checks++; if (rd_addr !== 9'd0) begin failures++; $display("FAIL reset_rd_addr got=%0d exp=0", rd_addr); end
      checks++; if (tx_data !== 8'h00) begin failures++; $display("FAIL reset_tx_data got=%0h exp=0", tx_data); end
      checks++; if (tx_valid !== 1'b0) begin failures++; $display("FAIL reset_tx_valid got=%b exp=0", tx_valid); end
      checks++; if (tx_last !== 1'b0) begin failures++; $display("FAIL reset_tx_last got=%b exp=0", tx_last); end
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
      checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", done); end
      start = 1'b1;
      tx_ready = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      checks++; if (busy !== 1'b1) begin failures++; $display("FAIL start_through_reset busy got=%b exp=1", busy); end
      start = 1'b0;
      seen = 0;
      n = 0;
      while (!seen && n < 3000) begin
         @(negedge clk);
         n++;
         if (done) seen = 1;
      end
      checks++; if (seen !== 1'b1) begin failures++; $display("FAIL start_through_reset_done got=%b exp=1", seen); end
      repeat (2) @(negedge clk);
   endtask

   // Full frame with sink always ready
   task automatic test_main_frame();
      run_frame(0, -1, 1, 0, -1);
      checks++; if (timed_out) begin failures++; $display("FAIL main_timeout got=1 exp=0"); end
      checks++; if (beats.size() !== DEPTH + 1) begin failures++; $display("FAIL main_beat_count got=%0d exp=%0d", beats.size(), DEPTH + 1); end
      checks++; if (seq_errors() !== 0) begin failures++; $display("FAIL main_sequence errors got=%0d exp=0", seq_errors()); end
      checks++; if (got_csum() !== model_csum()) begin failures++; $display("FAIL main_checksum got=%h exp=%h", got_csum(), model_csum()); end
      checks++; if (done_cnt !== 1) begin failures++; $display("FAIL main_done_pulses got=%0d exp=1", done_cnt); end
      checks++; if (busy_cycles !== 2 * DEPTH + 1) begin failures++; $display("FAIL main_busy_cycles got=%0d exp=%0d", busy_cycles, 2 * DEPTH + 1); end
      checks++; if (first_valid !== 2) begin failures++; $display("FAIL main_first_valid_latency got=%0d exp=2", first_valid); end
   endtask

   // Random backpressure: same beat stream, data stable while stalled
   task automatic test_backpressure();
      run_frame(1, -1, 1, 0, -1);
      checks++; if (timed_out) begin failures++; $display("FAIL bp_timeout got=1 exp=0"); end
      checks++; if (seq_errors() !== 0) begin failures++; $display("FAIL bp_sequence errors got=%0d exp=0", seq_errors()); end
      checks++; if (got_csum() !== model_csum()) begin failures++; $display("FAIL bp_checksum got=%h exp=%h", got_csum(), model_csum()); end
      checks++; if (stall_bad !== 0) begin failures++; $display("FAIL bp_stall_stability got=%0d exp=0", stall_bad); end
      checks++; if (done_cnt !== 1) begin failures++; $display("FAIL bp_done_pulses got=%0d exp=1", done_cnt); end
   endtask

   // Start edge mid-frame is ignored
   task automatic test_restart_ignored();
      run_frame(0, 100, 1, 0, -1);
      checks++; if (beats.size() !== DEPTH + 1) begin failures++; $display("FAIL restart_beat_count got=%0d exp=%0d", beats.size(), DEPTH + 1); end
      checks++; if (seq_errors() !== 0) begin failures++; $display("FAIL restart_sequence errors got=%0d exp=0", seq_errors()); end
      checks++; if (busy_after_done !== 0) begin failures++; $display("FAIL restart_queued busy_after_done got=%0d exp=0", busy_after_done); end
   endtask

   // Edge during done is dropped; a later edge yields an identical frame
   task automatic test_back_to_back();
      run_frame(0, -1, 1, 1, -1);
      checks++; if (done_cnt !== 1) begin failures++; $display("FAIL b2b_done_pulses got=%0d exp=1", done_cnt); end
      checks++; if (busy_after_done !== 0) begin failures++; $display("FAIL b2b_edge_on_done busy_after_done got=%0d exp=0", busy_after_done); end
      run_frame(0, -1, 1, 0, -1);
      checks++; if (seq_errors() !== 0) begin failures++; $display("FAIL b2b_second_sequence errors got=%0d exp=0", seq_errors()); end
      checks++; if (got_csum() !== model_csum()) begin failures++; $display("FAIL b2b_second_checksum got=%h exp=%h", got_csum(), model_csum()); end
   endtask

   // Mid-frame reset: outputs clear immediately, no done, next frame from sample 0
   task automatic test_reset_midframe();
      int dcount;
      run_frame(0, -1, 1, 0, 37);
      @(posedge clk);
      #2;
      rst = 1'b0;
      #1;
      checks++; if ({tx_valid, tx_last, busy, done} !== 4'b0000) begin failures++; $display("FAIL midrst_flags got=%b exp=0000", {tx_valid, tx_last, busy, done}); end
      checks++; if (tx_data !== 8'h00) begin failures++; $display("FAIL midrst_tx_data got=%h exp=00", tx_data); end
      checks++; if (rd_addr !== 9'd0) begin failures++; $display("FAIL midrst_rd_addr got=%0d exp=0", rd_addr); end
      dcount = 0;
      repeat (3) begin
         @(negedge clk);
         if (done) dcount++;
      end
      rst = 1'b1;
      repeat (2) begin
         @(negedge clk);
         if (done) dcount++;
      end
      checks++; if (dcount !== 0) begin failures++; $display("FAIL midrst_no_done got=%0d exp=0", dcount); end
      run_frame(0, -1, 1, 0, -1);
      checks++; if (seq_errors() !== 0) begin failures++; $display("FAIL midrst_restart_sequence errors got=%0d exp=0", seq_errors()); end
      checks++; if (done_cnt !== 1) begin failures++; $display("FAIL midrst_restart_done got=%0d exp=1", done_cnt); end
   endtask

   // Start held high for 20 cycles launches exactly one frame
   task automatic test_start_held();
      run_frame(0, -1, 20, 0, -1);
      checks++; if (beats.size() !== DEPTH + 1) begin failures++; $display("FAIL held_beat_count got=%0d exp=%0d", beats.size(), DEPTH + 1); end
      checks++; if (done_cnt !== 1) begin failures++; $display("FAIL held_done_pulses got=%0d exp=1", done_cnt); end
      checks++; if (busy_after_done !== 0) begin failures++; $display("FAIL held_second_frame busy_after_done got=%0d exp=0", busy_after_done); end
   endtask

   // DEPTH=1 instance: one 0xFF sample then a 0xFF checksum
   task automatic test_depth1();
      logic [7:0] b[$];
      logic       l[$];
      int         dn;
      dn = 0;
      @(negedge clk);
      start1 = 1'b1;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         start1 = 1'b0;
         if (done1) dn++;
         if (tx_valid1 && ready1) begin
            b.push_back(tx_data1);
            l.push_back(tx_last1);
         end
      end
      checks++; if (b.size() !== 2) begin failures++; $display("FAIL d1_beat_count got=%0d exp=2", b.size()); end
      if (b.size() == 2) begin
         checks++; if (b[0] !== 8'hFF || l[0] !== 1'b0) begin failures++; $display("FAIL d1_sample got=%h/%b exp=ff/0", b[0], l[0]); end
         checks++; if (b[1] !== 8'hFF || l[1] !== 1'b1) begin failures++; $display("FAIL d1_checksum got=%h/%b exp=ff/1", b[1], l[1]); end
      end
      checks++; if (dn !== 1) begin failures++; $display("FAIL d1_done_pulses got=%0d exp=1", dn); end
      checks++; if (rd_addr1 !== 1'b0 || busy1 !== 1'b0) begin failures++; $display("FAIL d1_idle got=%b%b exp=00", rd_addr1, busy1); end
   endtask

   initial begin
      test_reset();
      test_main_frame();
      test_backpressure();
      test_restart_ignored();
      test_back_to_back();
      test_reset_midframe();
      test_start_held();
      test_depth1();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule : tb_tdc_readout
`default_nettype wire
